// File: rtl/surf_dout_tx_framer.sv
// surf_dout_tx_framer
// SURF-side transmit framer for the 8-bit DOUT lane. Event bytes arrive on an
// AXI4-Stream slave. One byte per sysclk goes out to the DOUT OSERDES.
//
// Output stream:
//   - While training is requested, the 32-bit training word is sent MSB first.
//   - Each packet is preceded by START_BYTE.
//   - Idle cycles, and payload gaps (underflow), send IDLE_BYTE.
//
// Ports:
//   sysclk_i       - the only clock
//   sysclk_rst_i   - synchronous, active-high reset
//   train_i        - training request (level)
//   sync_i         - sysclk-aligned sync pulse; restarts the training word
//   s_dout_tdata   - payload byte
//   s_dout_tvalid  - payload valid
//   s_dout_tlast   - last payload byte of the packet
//   s_dout_tready  - high in DATA; a beat is tvalid & tready
//   dout_data_o    - registered byte to the OSERDES
//   training_o     - high alongside every training byte on dout_data_o
//   underflow_o    - 1-cycle pulse alongside the IDLE_BYTE of a payload gap
//   overlong_o     - 1-cycle pulse alongside the byte that hit MAX_LEN
//   pkt_count_o    - packets completed; wraps 16'hFFFF -> 0
//
// All status outputs are registered together with dout_data_o. This keeps
// each flag on the same cycle as the byte it describes.
module surf_dout_tx_framer #(
    parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
    parameter logic [7:0]  IDLE_BYTE      = 8'h00,
    parameter logic [7:0]  START_BYTE     = 8'hFF,
    parameter int unsigned MAX_LEN        = 4096
) (
    input  logic        sysclk_i,
    input  logic        sysclk_rst_i,
    input  logic        train_i,
    input  logic        sync_i,
    input  logic [7:0]  s_dout_tdata,
    input  logic        s_dout_tvalid,
    input  logic        s_dout_tlast,
    output logic        s_dout_tready,
    output logic [7:0]  dout_data_o,
    output logic        training_o,
    output logic        underflow_o,
    output logic        overlong_o,
    output logic [15:0] pkt_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_TRAIN
    } state_t;

    // The length counter holds bytes already accepted. So the beat that
    // becomes byte MAX_LEN arrives while the counter reads MAX_LEN-1.
    localparam logic [15:0] LAST_BYTE_CNT = 16'(MAX_LEN - 1);

    state_t      state, state_next;
    logic [1:0]  idx, idx_next;
    logic [15:0] len_cnt, len_next;
    logic [7:0]  dout_next;
    logic        training_next;
    logic        underflow_next;
    logic        overlong_next;
    logic        pkt_done;
    logic [7:0]  train_byte;

    // Select the byte of the training word that goes out for the current index.
    always_comb begin
        train_byte = TRAIN_SEQUENCE[31:24];
        case (idx)
            2'd0: train_byte = TRAIN_SEQUENCE[31:24];
            2'd1: train_byte = TRAIN_SEQUENCE[23:16];
            2'd2: train_byte = TRAIN_SEQUENCE[15:8];
            2'd3: train_byte = TRAIN_SEQUENCE[7:0];
            default: train_byte = TRAIN_SEQUENCE[31:24];
        endcase
    end

    // Next-state logic. It also chooses the byte that will appear on
    // dout_data_o in the following cycle.
    always_comb begin
        state_next     = state;
        idx_next       = idx;
        len_next       = len_cnt;
        dout_next      = IDLE_BYTE;
        training_next  = 1'b0;
        underflow_next = 1'b0;
        overlong_next  = 1'b0;
        pkt_done       = 1'b0;
        s_dout_tready  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (train_i) begin
                    state_next = ST_TRAIN;
                    idx_next   = 2'd0;
                end else if (s_dout_tvalid) begin
                    state_next = ST_HDR;
                    len_next   = 16'd0;
                end
            end

            ST_HDR: begin
                dout_next  = START_BYTE;
                state_next = ST_DATA;
            end

            ST_DATA: begin
                s_dout_tready = 1'b1;
                if (s_dout_tvalid) begin
                    dout_next = s_dout_tdata;
                    len_next  = len_cnt + 16'd1;
                    if (s_dout_tlast) begin
                        pkt_done   = 1'b1;
                        state_next = ST_IDLE;
                    end else if (len_cnt == LAST_BYTE_CNT) begin
                        // Truncate here. The source's remaining bytes are
                        // still pending, so they start a fresh packet.
                        pkt_done      = 1'b1;
                        overlong_next = 1'b1;
                        state_next    = ST_IDLE;
                    end
                end else begin
                    underflow_next = 1'b1;
                end
            end

            ST_TRAIN: begin
                dout_next     = train_byte;
                training_next = 1'b1;
                // Leave only after the last byte of the word, so the
                // receiver never sees a partial word.
                if (!train_i && idx == 2'd3) begin
                    state_next = ST_IDLE;
                    idx_next   = 2'd0;
                end else if (sync_i) begin
                    idx_next = 2'd0;
                end else begin
                    idx_next = idx + 2'd1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // State, counters and the registered output stage.
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            len_cnt     <= 16'd0;
            dout_data_o <= IDLE_BYTE;
            training_o  <= 1'b0;
            underflow_o <= 1'b0;
            overlong_o  <= 1'b0;
            pkt_count_o <= 16'd0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            len_cnt     <= len_next;
            dout_data_o <= dout_next;
            training_o  <= training_next;
            underflow_o <= underflow_next;
            overlong_o  <= overlong_next;
            if (pkt_done) begin
                pkt_count_o <= pkt_count_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_surf_dout_tx_framer.sv
// tb_surf_dout_tx_framer
// Directed bench for surf_dout_tx_framer. The DUT is built with MAX_LEN=4 so
// that truncation can be reached with short packets.
//
// The bench runs one cycle at a time:
//   - Inputs are set 1ns after a rising edge.
//   - The next rising edge consumes them.
//   - Outputs are sampled 1ns after that edge.
//
// Each cycle then shows the byte the design chose while seeing those inputs.
module tb_surf_dout_tx_framer;

    logic        sysclk_i;
    logic        sysclk_rst_i;
    logic        train_i;
    logic        sync_i;
    logic [7:0]  s_dout_tdata;
    logic        s_dout_tvalid;
    logic        s_dout_tlast;
    logic        s_dout_tready;
    logic [7:0]  dout_data_o;
    logic        training_o;
    logic        underflow_o;
    logic        overlong_o;
    logic [15:0] pkt_count_o;

    int checkCount;
    int passCount;

    logic [7:0] trainBytes [4];

    surf_dout_tx_framer #(
        .TRAIN_SEQUENCE(32'hA55A6996),
        .IDLE_BYTE     (8'h00),
        .START_BYTE    (8'hFF),
        .MAX_LEN       (4)
    ) dut (
        .sysclk_i     (sysclk_i),
        .sysclk_rst_i (sysclk_rst_i),
        .train_i      (train_i),
        .sync_i       (sync_i),
        .s_dout_tdata (s_dout_tdata),
        .s_dout_tvalid(s_dout_tvalid),
        .s_dout_tlast (s_dout_tlast),
        .s_dout_tready(s_dout_tready),
        .dout_data_o  (dout_data_o),
        .training_o   (training_o),
        .underflow_o  (underflow_o),
        .overlong_o   (overlong_o),
        .pkt_count_o  (pkt_count_o)
    );

    // 100 MHz sysclk.
    initial sysclk_i = 1'b0;
    always #5 sysclk_i = ~sysclk_i;

    // Drive one cycle of inputs, let the edge consume them, then settle.
    task automatic applyStimulus(input logic train, input logic sync,
                                 input logic valid, input logic [7:0] data,
                                 input logic last);
        train_i       = train;
        sync_i        = sync;
        s_dout_tvalid = valid;
        s_dout_tdata  = data;
        s_dout_tlast  = last;
        @(posedge sysclk_i);
        #1;
    endtask

    // Single comparison point. Every check is counted and reported here.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Check the byte and the flags {training, underflow, overlong}.
    task automatic checkCycle(input string tag, input logic [7:0] expDout,
                              input logic [2:0] expFlags);
        checkOutput({tag, "_dout"}, {8'h00, dout_data_o}, {8'h00, expDout});
        checkOutput({tag, "_flags"}, {13'd0, training_o, underflow_o, overlong_o},
                    {13'd0, expFlags});
    endtask

    initial begin
        checkCount    = 0;
        passCount     = 0;
        trainBytes    = '{8'hA5, 8'h5A, 8'h69, 8'h96};
        sysclk_rst_i  = 1'b1;
        train_i       = 1'b0;
        sync_i        = 1'b0;
        s_dout_tvalid = 1'b0;
        s_dout_tdata  = 8'h00;
        s_dout_tlast  = 1'b0;

        // Reset state.
        repeat (2) @(posedge sysclk_i);
        #1;
        checkCycle("rst", 8'h00, 3'b000);
        checkOutput("rst_tready", {15'd0, s_dout_tready}, 16'd0);
        checkOutput("rst_pkt", pkt_count_o, 16'd0);
        sysclk_rst_i = 1'b0;

        // Training held for 12 cycles: three whole words, then idle.
        applyStimulus(1, 0, 0, 8'h00, 0);
        checkCycle("trn_entry", 8'h00, 3'b000);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(k < 11, 0, 0, 8'h00, 0);
            checkCycle("trn_word", trainBytes[k % 4], 3'b100);
        end
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("trn_exit", 8'h00, 3'b000);

        // Sync restarts the word.
        // train_i is dropped mid-word; the word must still finish.
        applyStimulus(1, 0, 0, 8'h00, 0);
        checkCycle("sync_entry", 8'h00, 3'b000);
        applyStimulus(1, 0, 0, 8'h00, 0);
        checkCycle("sync_b0", 8'hA5, 3'b100);
        applyStimulus(1, 1, 0, 8'h00, 0);
        checkCycle("sync_b1", 8'h5A, 3'b100);
        applyStimulus(1, 0, 0, 8'h00, 0);
        checkCycle("sync_restart", 8'hA5, 3'b100);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("sync_b1b", 8'h5A, 3'b100);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("sync_b2", 8'h69, 3'b100);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("sync_b3", 8'h96, 3'b100);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("sync_exit", 8'h00, 3'b000);

        // Plain packet 11,22,33.
        applyStimulus(0, 0, 1, 8'h11, 0);
        checkCycle("p1_idle", 8'h00, 3'b000);
        checkOutput("p1_hdr_tready", {15'd0, s_dout_tready}, 16'd0);
        applyStimulus(0, 0, 1, 8'h11, 0);
        checkCycle("p1_start", 8'hFF, 3'b000);
        checkOutput("p1_data_tready", {15'd0, s_dout_tready}, 16'd1);
        applyStimulus(0, 0, 1, 8'h11, 0);
        checkCycle("p1_b1", 8'h11, 3'b000);
        applyStimulus(0, 0, 1, 8'h22, 0);
        checkCycle("p1_b2", 8'h22, 3'b000);
        checkOutput("p1_pkt_mid", pkt_count_o, 16'd0);
        applyStimulus(0, 0, 1, 8'h33, 1);
        checkCycle("p1_b3", 8'h33, 3'b000);
        checkOutput("p1_pkt", pkt_count_o, 16'd1);
        checkOutput("p1_tready_off", {15'd0, s_dout_tready}, 16'd0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("p1_tail", 8'h00, 3'b000);

        // Underflow: two empty cycles after byte 22.
        applyStimulus(0, 0, 1, 8'h11, 0);
        checkCycle("uf_idle", 8'h00, 3'b000);
        applyStimulus(0, 0, 1, 8'h11, 0);
        checkCycle("uf_start", 8'hFF, 3'b000);
        applyStimulus(0, 0, 1, 8'h11, 0);
        checkCycle("uf_b1", 8'h11, 3'b000);
        applyStimulus(0, 0, 1, 8'h22, 0);
        checkCycle("uf_b2", 8'h22, 3'b000);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("uf_gap1", 8'h00, 3'b010);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("uf_gap2", 8'h00, 3'b010);
        applyStimulus(0, 0, 1, 8'h33, 1);
        checkCycle("uf_b3", 8'h33, 3'b000);
        checkOutput("uf_pkt", pkt_count_o, 16'd2);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("uf_tail", 8'h00, 3'b000);

        // Overlong: six bytes against MAX_LEN=4, split into two packets.
        applyStimulus(0, 0, 1, 8'hB1, 0);
        checkCycle("ol_idle", 8'h00, 3'b000);
        applyStimulus(0, 0, 1, 8'hB1, 0);
        checkCycle("ol_start", 8'hFF, 3'b000);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 0, 1, 8'hB0 + 8'(k), 0);
            checkCycle("ol_byte", 8'hB0 + 8'(k), 3'b000);
        end
        applyStimulus(0, 0, 1, 8'hB4, 0);
        checkCycle("ol_trunc", 8'hB4, 3'b001);
        checkOutput("ol_pkt_a", pkt_count_o, 16'd3);
        applyStimulus(0, 0, 1, 8'hB5, 0);
        checkCycle("ol_gap", 8'h00, 3'b000);
        applyStimulus(0, 0, 1, 8'hB5, 0);
        checkCycle("ol_start2", 8'hFF, 3'b000);
        applyStimulus(0, 0, 1, 8'hB5, 0);
        checkCycle("ol_b5", 8'hB5, 3'b000);
        applyStimulus(0, 0, 1, 8'hB6, 1);
        checkCycle("ol_b6", 8'hB6, 3'b000);
        checkOutput("ol_pkt_b", pkt_count_o, 16'd4);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("ol_tail", 8'h00, 3'b000);

        // Exactly MAX_LEN bytes with tlast on the last one is not overlong.
        applyStimulus(0, 0, 1, 8'hC1, 0);
        applyStimulus(0, 0, 1, 8'hC1, 0);
        checkCycle("ml_start", 8'hFF, 3'b000);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 1, 8'hC0 + 8'(k), k == 4);
            checkCycle("ml_byte", 8'hC0 + 8'(k), 3'b000);
        end
        checkOutput("ml_pkt", pkt_count_o, 16'd5);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("ml_tail", 8'h00, 3'b000);

        // One-byte packet.
        applyStimulus(0, 0, 1, 8'h77, 1);
        applyStimulus(0, 0, 1, 8'h77, 1);
        checkCycle("one_start", 8'hFF, 3'b000);
        applyStimulus(0, 0, 1, 8'h77, 1);
        checkCycle("one_b", 8'h77, 3'b000);
        checkOutput("one_pkt", pkt_count_o, 16'd6);
        checkOutput("one_tready_off", {15'd0, s_dout_tready}, 16'd0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("one_tail", 8'h00, 3'b000);

        // Training requested mid-packet waits for the packet to finish.
        applyStimulus(0, 0, 1, 8'h11, 0);
        applyStimulus(0, 0, 1, 8'h11, 0);
        checkCycle("tm_start", 8'hFF, 3'b000);
        applyStimulus(1, 0, 1, 8'h11, 0);
        checkCycle("tm_b1", 8'h11, 3'b000);
        applyStimulus(1, 0, 1, 8'h22, 0);
        checkCycle("tm_b2", 8'h22, 3'b000);
        applyStimulus(1, 0, 1, 8'h33, 1);
        checkCycle("tm_b3", 8'h33, 3'b000);
        checkOutput("tm_pkt", pkt_count_o, 16'd7);
        applyStimulus(1, 0, 0, 8'h00, 0);
        checkCycle("tm_idle", 8'h00, 3'b000);
        applyStimulus(1, 0, 0, 8'h00, 0);
        checkCycle("tm_w0", 8'hA5, 3'b100);
        for (int k = 1; k < 4; k++) begin
            applyStimulus(0, 0, 0, 8'h00, 0);
            checkCycle("tm_word", trainBytes[k], 3'b100);
        end
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("tm_exit", 8'h00, 3'b000);

        // Reset mid-packet abandons the packet without an error pulse.
        applyStimulus(0, 0, 1, 8'h11, 0);
        applyStimulus(0, 0, 1, 8'h11, 0);
        applyStimulus(0, 0, 1, 8'h11, 0);
        checkCycle("mr_b1", 8'h11, 3'b000);
        sysclk_rst_i = 1'b1;
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("mr_rst", 8'h00, 3'b000);
        checkOutput("mr_pkt", pkt_count_o, 16'd0);
        checkOutput("mr_tready", {15'd0, s_dout_tready}, 16'd0);
        sysclk_rst_i = 1'b0;
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkCycle("mr_after", 8'h00, 3'b000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
